st_timing_adapter_fifo: RTL and testbench
=========================================

ST_TIMING_ADAPTER_FIFO -- requirements
Module: st_timing_adapter_fifo

Interface
REQ-001 Parameter DATA_W, default 32, width of in_data/out_data.
REQ-002 Parameter EMPTY_W, default 2, width of in_empty/out_empty.
REQ-003 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 4..256.
REQ-004 Parameter IN_READY_LATENCY, default 0, upstream ready latency 0..3.
REQ-005 Derived FILL_W = clog2(DEPTH)+1.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 in_ready  out  1  sink ready toward upstream.
REQ-009 in_valid, in_startofpacket, in_endofpacket  in  1 each  sink beat qualifiers.
REQ-010 in_data  in  DATA_W; in_empty  in  EMPTY_W  sink payload.
REQ-011 out_ready  in  1  downstream ready, ready latency 0.
REQ-012 out_valid, out_startofpacket, out_endofpacket  out  1 each  source qualifiers.
REQ-013 out_data  out  DATA_W; out_empty  out  EMPTY_W  source payload.
REQ-014 fill_level  out  FILL_W  current occupied entries.
REQ-015 overflow  out  1  sticky: a beat was dropped.
REQ-016 protocol_error  out  1  sticky: sop/eop framing violation seen on input.

Function
REQ-017 Storage SHALL hold DEPTH entries of {data, sop, eop, empty}, stored and returned bit-exact.
REQ-018 in_ready SHALL be combinational: (fill_level < DEPTH - IN_READY_LATENCY).
REQ-019 IN_READY_LATENCY=0: beat accepted when in_valid && in_ready.
REQ-020 IN_READY_LATENCY>0: beat accepted whenever in_valid=1 (source honours latency); ready only gates issue.
REQ-021 Write SHALL occur if beat accepted and (fill_level < DEPTH or a read occurs same cycle).
REQ-022 Accepted beat that cannot be written SHALL be dropped and overflow set to 1 next cycle, held until reset.
REQ-023 Show-ahead output: out_valid = (fill_level != 0); out payload = head entry, no bubble.
REQ-024 Read SHALL occur on out_valid && out_ready; head advances next cycle.
REQ-025 Latency: beat written at edge N SHALL appear on out_valid at cycle N+1 (one cycle, empty FIFO).
REQ-026 Payload outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 Read and write pointers clog2(DEPTH) bits, wrap modulo DEPTH; fill_level = writes - reads, registered.
REQ-028 Simultaneous write+read: fill_level unchanged; both pointers advance.
REQ-029 Read when empty or write when full (without read) SHALL not change pointers or fill_level.
REQ-030 Framing FSM states IDLE, IN_PKT, evaluated on accepted beats only.
REQ-031 IDLE: sop&eop -> IDLE; sop&!eop -> IN_PKT; !sop -> protocol_error=1, state unchanged.
REQ-032 IN_PKT: sop -> protocol_error=1, remain IN_PKT; eop -> IDLE; else stay.
REQ-033 Framing violations SHALL NOT alter storage; offending beats are stored normally.
REQ-034 Dropped beats SHALL still update the framing FSM.

Reset
REQ-035 reset=1 at edge: pointers=0, fill_level=0, FSM=IDLE, overflow=0, protocol_error=0.
REQ-036 During/after reset out_valid=0; in_ready=1 (DEPTH > IN_READY_LATENCY); storage contents not reset.
REQ-037 Reset mid-packet or mid-transfer SHALL discard all stored beats; reset wins over simultaneous read/write.

Verification
V1 DEPTH=16,L=0: write 0x11223344 sop+eop, out_ready=1 -> out_valid next cycle, data 0x11223344, sop=eop=1, fill back to 0.
V2 DEPTH=16,L=0, out_ready=0, 20 valid beats -> 16 stored, in_ready=0 at fill 16, overflow=0; drain yields beats 0..15 in order.
V3 DEPTH=16,L=2, out_ready=0 -> in_ready=0 at fill 14; two further beats accepted to fill 16; third beat dropped, overflow=1.
V4 Full FIFO, L=2, in_valid and out_ready same cycle -> write and read both occur, fill_level stays 16, overflow=0.
V5 Beats: eop without sop, then sop, sop -> protocol_error=1 after first beat; all three stored and output.
V6 Fill 5 beats, assert reset one cycle mid-packet -> fill_level=0, out_valid=0, state IDLE, flags 0.

Source files
------------

// File: rtl/st_timing_adapter_fifo.sv
// Show-ahead streaming FIFO that lets an upstream with ready latency 0..3 feed a ready-latency-0 sink.
// Write-to-output latency is one cycle. Beats accepted while full are dropped and latched as overflow.
module st_timing_adapter_fifo #(
   parameter int DATA_W           = 32,
   parameter int EMPTY_W          = 2,
   parameter int DEPTH            = 16,
   parameter int IN_READY_LATENCY = 0,
   localparam int FILL_W          = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   output logic               in_ready,
   input  logic               in_valid,
   input  logic               in_startofpacket,
   input  logic               in_endofpacket,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [EMPTY_W-1:0] in_empty,
   input  logic               out_ready,
   output logic               out_valid,
   output logic               out_startofpacket,
   output logic               out_endofpacket,
   output logic [DATA_W-1:0]  out_data,
   output logic [EMPTY_W-1:0] out_empty,
   output logic [FILL_W-1:0]  fill_level,
   output logic               overflow,
   output logic               protocol_error
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_W + EMPTY_W + 2;
   localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);
   localparam logic [FILL_W-1:0] RDY_LVL  = FILL_W'(DEPTH - IN_READY_LATENCY);

   typedef enum logic {IDLE, IN_PKT} state_t;

   logic [EW-1:0]     r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [FILL_W-1:0] r_fill;
   logic              r_overflow;
   logic              r_perr;
   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_perr_set;
   logic              w_accept;
   logic              w_wr;
   logic              w_rd;
   logic [EW-1:0]     w_head;

   // With nonzero ready latency the source keeps sending for a few cycles after
   // ready drops, so every valid beat counts as accepted.
   assign in_ready = (r_fill < RDY_LVL);
   assign w_accept = in_valid && ((IN_READY_LATENCY != 0) || in_ready);
   assign w_rd     = (r_fill != '0) && out_ready;
   assign w_wr     = w_accept && ((r_fill < FULL_LVL) || w_rd);

   always_ff @(posedge clk) begin
      if (w_wr && !reset) begin
         r_mem[r_wr_ptr] <= {in_data, in_startofpacket, in_endofpacket, in_empty};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill     <= '0;
         r_overflow <= 1'b0;
         r_perr     <= 1'b0;
         r_state    <= IDLE;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_wr && !w_rd) begin
            r_fill <= r_fill + FILL_W'(1);
         end else if (!w_wr && w_rd) begin
            r_fill <= r_fill - FILL_W'(1);
         end
         if (w_accept && !w_wr) r_overflow <= 1'b1;
         if (w_perr_set) r_perr <= 1'b1;
         r_state <= w_state_nxt;
      end
   end

   // Framing follows every accepted beat, including ones dropped for lack of space.
   always_comb begin
      w_state_nxt = r_state;
      w_perr_set  = 1'b0;
      if (w_accept) begin
         case (r_state)
            IDLE: begin
               if (!in_startofpacket) begin
                  w_perr_set = 1'b1;
               end else if (!in_endofpacket) begin
                  w_state_nxt = IN_PKT;
               end
            end
            IN_PKT: begin
               if (in_startofpacket) begin
                  w_perr_set = 1'b1;
               end else if (in_endofpacket) begin
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign w_head = r_mem[r_rd_ptr];
   assign {out_data, out_startofpacket, out_endofpacket, out_empty} = w_head;
   assign out_valid      = (r_fill != '0);
   assign fill_level     = r_fill;
   assign overflow       = r_overflow;
   assign protocol_error = r_perr;

endmodule

// File: tb/tb_st_timing_adapter_fifo.sv
// Bench: two DUT instances (ready latency 0 and 2) checked against a queue model each cycle.
module tb_st_timing_adapter_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_ready   [2];
   logic        in_valid   [2];
   logic        in_sop     [2];
   logic        in_eop     [2];
   logic [31:0] in_data    [2];
   logic [1:0]  in_empty   [2];
   logic        out_ready  [2];
   logic        out_valid  [2];
   logic        out_sop    [2];
   logic        out_eop    [2];
   logic [31:0] out_data   [2];
   logic [1:0]  out_empty  [2];
   logic [4:0]  fill_level [2];
   logic        overflow   [2];
   logic        perr       [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      st_timing_adapter_fifo #(
         .DATA_W(32), .EMPTY_W(2), .DEPTH(16), .IN_READY_LATENCY(g * 2)
      ) dut (
         .clk              (clk),
         .reset            (reset),
         .in_ready         (in_ready[g]),
         .in_valid         (in_valid[g]),
         .in_startofpacket (in_sop[g]),
         .in_endofpacket   (in_eop[g]),
         .in_data          (in_data[g]),
         .in_empty         (in_empty[g]),
         .out_ready        (out_ready[g]),
         .out_valid        (out_valid[g]),
         .out_startofpacket(out_sop[g]),
         .out_endofpacket  (out_eop[g]),
         .out_data         (out_data[g]),
         .out_empty        (out_empty[g]),
         .fill_level       (fill_level[g]),
         .overflow         (overflow[g]),
         .protocol_error   (perr[g])
      );
   end

   // Reference model: a queue of {data, sop, eop, empty} per instance.
   logic [35:0] mq [2][$];
   bit          m_ovf   [2];
   bit          m_perr  [2];
   bit          m_inpkt [2];
   int          lat     [2] = '{0, 2};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d t=%0t actual=%h required=%h", nm, g, $time, act, exp);
      end
   endtask

   task automatic model_step();
      for (int g = 0; g < 2; g++) begin
         int sz;
         bit rd, acc, wr;
         sz = mq[g].size();
         if (reset) begin
            mq[g].delete();
            m_ovf[g]   = 0;
            m_perr[g]  = 0;
            m_inpkt[g] = 0;
         end else begin
            rd  = (sz != 0) && out_ready[g];
            acc = in_valid[g] && (lat[g] != 0 || sz < 16 - lat[g]);
            wr  = acc && (sz < 16 || rd);
            if (acc && !wr) m_ovf[g] = 1;
            if (acc) begin
               if (!m_inpkt[g]) begin
                  if (!in_sop[g]) m_perr[g] = 1;
                  else m_inpkt[g] = !in_eop[g];
               end else begin
                  if (in_sop[g]) m_perr[g] = 1;
                  else if (in_eop[g]) m_inpkt[g] = 0;
               end
            end
            if (rd) void'(mq[g].pop_front());
            if (wr) mq[g].push_back({in_data[g], in_sop[g], in_eop[g], in_empty[g]});
         end
      end
   endtask

   task automatic check_all();
      for (int g = 0; g < 2; g++) begin
         int sz;
         logic [35:0] h;
         sz = mq[g].size();
         chk("in_ready", g, in_ready[g], sz < 16 - lat[g]);
         chk("out_valid", g, out_valid[g], sz != 0);
         chk("fill_level", g, fill_level[g], sz);
         chk("overflow", g, overflow[g], m_ovf[g]);
         chk("protocol_error", g, perr[g], m_perr[g]);
         if (sz != 0) begin
            h = mq[g][0];
            chk("out_data", g, out_data[g], h[35:4]);
            chk("out_sop", g, out_sop[g], h[3]);
            chk("out_eop", g, out_eop[g], h[2]);
            chk("out_empty", g, out_empty[g], h[1:0]);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic set_in(input int g, input bit v, input bit s, input bit e,
                         input logic [31:0] d, input logic [1:0] emp);
      in_valid[g] = v;
      in_sop[g]   = s;
      in_eop[g]   = e;
      in_data[g]  = d;
      in_empty[g] = emp;
   endtask

   task automatic idle_all();
      for (int g = 0; g < 2; g++) begin
         set_in(g, 0, 0, 0, 32'h0, 2'b0);
         out_ready[g] = 0;
      end
   endtask

   initial begin
      reset = 1;
      idle_all();
      tick();
      tick();
      reset = 0;
      for (int g = 0; g < 2; g++) begin
         chk("rst_fill", g, fill_level[g], 0);
         chk("rst_out_valid", g, out_valid[g], 0);
         chk("rst_in_ready", g, in_ready[g], 1);
      end

      // Single sop+eop beat, one-cycle latency, then drained.
      set_in(0, 1, 1, 1, 32'h11223344, 2'd2);
      out_ready[0] = 1;
      tick();
      set_in(0, 0, 0, 0, 32'h0, 2'b0);
      chk("v1_valid", 0, out_valid[0], 1);
      chk("v1_data", 0, out_data[0], 32'h11223344);
      chk("v1_sop_eop", 0, {out_sop[0], out_eop[0]}, 2'b11);
      tick();
      chk("v1_fill", 0, fill_level[0], 0);

      // Latency 0: twenty offered beats, only sixteen taken, no overflow.
      out_ready[0] = 0;
      for (int k = 0; k < 20; k++) begin
         set_in(0, 1, k == 0, k == 19, k, 2'(k));
         tick();
      end
      set_in(0, 0, 0, 0, 32'h0, 2'b0);
      chk("v2_fill", 0, fill_level[0], 16);
      chk("v2_in_ready", 0, in_ready[0], 0);
      chk("v2_overflow", 0, overflow[0], 0);
      out_ready[0] = 1;
      for (int k = 0; k < 16; k++) begin
         chk("v2_order", 0, out_data[0], k);
         tick();
      end
      out_ready[0] = 0;
      chk("v2_drained", 0, out_valid[0], 0);

      // Latency 2: ready drops at 14, two more land, the third is dropped.
      for (int k = 0; k < 14; k++) begin
         set_in(1, 1, k == 0, 0, k, 2'b0);
         tick();
      end
      chk("v3_fill14", 1, fill_level[1], 14);
      chk("v3_in_ready", 1, in_ready[1], 0);
      tick();
      tick();
      chk("v3_fill16", 1, fill_level[1], 16);
      chk("v3_no_ovf", 1, overflow[1], 0);
      tick();
      set_in(1, 0, 0, 0, 32'h0, 2'b0);
      chk("v3_ovf", 1, overflow[1], 1);
      chk("v3_fill_hold", 1, fill_level[1], 16);

      // Full FIFO with simultaneous write and read.
      reset = 1;
      tick();
      reset = 0;
      for (int k = 0; k < 16; k++) begin
         set_in(1, 1, k == 0, 0, 32'h200 + k, 2'b0);
         tick();
      end
      chk("v4_pre_ovf", 1, overflow[1], 0);
      set_in(1, 1, 0, 1, 32'h2FF, 2'b0);
      out_ready[1] = 1;
      tick();
      set_in(1, 0, 0, 0, 32'h0, 2'b0);
      out_ready[1] = 0;
      chk("v4_fill", 1, fill_level[1], 16);
      chk("v4_ovf", 1, overflow[1], 0);
      chk("v4_head", 1, out_data[1], 32'h201);

      // Reset in the middle of a packet that already flagged an error.
      for (int k = 0; k < 5; k++) begin
         set_in(0, 1, k < 2, 0, 32'h300 + k, 2'b0);
         tick();
      end
      set_in(0, 0, 0, 0, 32'h0, 2'b0);
      chk("v6_pre_perr", 0, perr[0], 1);
      chk("v6_pre_fill", 0, fill_level[0], 5);
      reset = 1;
      tick();
      reset = 0;
      chk("v6_fill", 0, fill_level[0], 0);
      chk("v6_valid", 0, out_valid[0], 0);
      chk("v6_perr", 0, perr[0], 0);
      chk("v6_ovf", 0, overflow[0], 0);

      // Framing errors: eop without sop, then two sops; all stored.
      set_in(0, 1, 0, 1, 32'hA, 2'd1);
      tick();
      chk("v5_perr", 0, perr[0], 1);
      set_in(0, 1, 1, 0, 32'hB, 2'd2);
      tick();
      set_in(0, 1, 1, 0, 32'hC, 2'd3);
      tick();
      set_in(0, 0, 0, 0, 32'h0, 2'b0);
      chk("v5_fill", 0, fill_level[0], 3);
      out_ready[0] = 1;
      chk("v5_a", 0, {out_data[0], out_sop[0], out_eop[0]}, {32'hA, 2'b01});
      tick();
      chk("v5_b", 0, {out_data[0], out_sop[0], out_eop[0]}, {32'hB, 2'b10});
      tick();
      chk("v5_c", 0, {out_data[0], out_sop[0], out_eop[0]}, {32'hC, 2'b10});
      tick();
      out_ready[0] = 0;

      reset = 1;
      tick();
      reset = 0;

      for (int c = 0; c < 4000; c++) begin
         int bias;
         bias  = ((c / 500) % 2 == 1) ? 30 : 85;
         reset = ($urandom_range(0, 599) == 0);
         for (int g = 0; g < 2; g++) begin
            set_in(g, $urandom_range(0, 99) < 70, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, $urandom, 2'($urandom));
            out_ready[g] = $urandom_range(0, 99) < bias;
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
